// File: rtl/studio2_pkg.sv
// Shared constants and types for the Studio II dual keypad emulation.
package studio2_pkg;

  localparam int unsigned NUM_KEYS  = 10;
  localparam int unsigned CODE_W    = 8;
  localparam int unsigned SEL_W     = 4;
  localparam int unsigned IO_N_W    = 3;

  typedef logic [NUM_KEYS-1:0] kp_vec_t;

  localparam logic [SEL_W-1:0]  KEY_NONE    = 4'hF;
  localparam logic [SEL_W-1:0]  MAX_DIGIT   = 4'd9;
  localparam logic [IO_N_W-1:0] IO_N_KEYSEL = 3'b010;

  // PS/2 set-2 scan codes, index = keypad digit
  localparam logic [CODE_W-1:0] KP1_CODES [NUM_KEYS] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
  };
  localparam logic [CODE_W-1:0] KP2_CODES [NUM_KEYS] = '{
    8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
  };

  // State of the selected digit; selects above 9 read as not held
  function automatic logic key_bit(input kp_vec_t keys, input logic [SEL_W-1:0] sel);
    logic held;
    held = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (sel == SEL_W'(i)) held = keys[i];
    end
    return held;
  endfunction

endpackage

// File: rtl/studio2_keymap.sv
// Scan-code decoder: maps a non-extended PS/2 code to a keypad and digit.
module studio2_keymap
  import studio2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       extended,
  output logic       hit,
  output logic       pad,
  output logic [3:0] digit
);

  // Table lookup; extended codes never match so arrows stay off the numpad
  always_comb begin
    hit   = 1'b0;
    pad   = 1'b0;
    digit = 4'd0;
    if (!extended) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (code == KP1_CODES[i]) begin
          hit   = 1'b1;
          pad   = 1'b0;
          digit = 4'(i);
        end
        if (code == KP2_CODES[i]) begin
          hit   = 1'b1;
          pad   = 1'b1;
          digit = 4'(i);
        end
      end
    end
  end

endmodule

// File: rtl/studio2_keypad.sv
// Dual hex keypad for the Studio II: PS/2 events to key vectors, OUT 2 key select, EF3/EF4 flags.
module studio2_keypad
  import studio2_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 500000,
  parameter int unsigned HOLD_W      = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        io_out,
  input  logic [2:0]  io_n,
  input  logic [7:0]  io_dout,
  output logic        ef3_n,
  output logic        ef4_n,
  output logic [9:0]  kp1_keys,
  output logic [9:0]  kp2_keys,
  output logic [3:0]  key_sel
);

  localparam int unsigned NUM_PADS = 2;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] CNT_ONE   = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] CNT_ZERO  = '0;

  logic              toggle_q;
  logic              key_ev_c;
  logic              map_hit;
  logic              map_pad;
  logic [3:0]        map_digit;
  kp_vec_t           digit_mask;

  kp_vec_t           keys_q [NUM_PADS];
  kp_vec_t           keys_d [NUM_PADS];
  kp_vec_t           pend_q [NUM_PADS];
  kp_vec_t           pend_d [NUM_PADS];
  logic [HOLD_W-1:0] cnt_q  [NUM_PADS];
  logic [HOLD_W-1:0] cnt_d  [NUM_PADS];

  logic [SEL_W-1:0]  key_sel_q;
  logic [SEL_W-1:0]  key_sel_d;
  logic              ef3_q;
  logic              ef3_d;
  logic              ef4_q;
  logic              ef4_d;

  logic              unused_dout_hi;
  assign unused_dout_hi = ^io_dout[7:4];

  studio2_keymap u_keymap (
    .code     (ps2_key[7:0]),
    .extended (ps2_key[8]),
    .hit      (map_hit),
    .pad      (map_pad),
    .digit    (map_digit)
  );

  // A new PS/2 event is signalled by a flip of the toggle strobe
  assign key_ev_c   = ps2_key[10] ^ toggle_q;
  assign digit_mask = kp_vec_t'(1) << map_digit;

  // Key vectors, hold counters, pending releases, key select and EF flags
  always_comb begin
    for (int p = 0; p < NUM_PADS; p++) begin
      keys_d[p] = keys_q[p];
      pend_d[p] = pend_q[p];
      cnt_d[p]  = cnt_q[p];

      if (cnt_q[p] != CNT_ZERO) cnt_d[p] = cnt_q[p] - CNT_ONE;

      // Counter stepping 1->0 releases every break that arrived during the hold
      if (cnt_q[p] == CNT_ONE) begin
        keys_d[p] = keys_q[p] & ~pend_q[p];
        pend_d[p] = '0;
      end

      if (key_ev_c && map_hit && (map_pad == 1'(p))) begin
        if (ps2_key[9]) begin
          // Make wins over a same-cycle expiry: earlier pending releases are dropped
          keys_d[p] = keys_q[p] | digit_mask;
          pend_d[p] = '0;
          cnt_d[p]  = HOLD_LOAD;
        end else if (cnt_q[p] <= CNT_ONE) begin
          // No hold left after this cycle, so release now rather than strand it in pending
          keys_d[p] = keys_d[p] & ~digit_mask;
        end else begin
          pend_d[p] = pend_q[p] | digit_mask;
        end
      end
    end

    key_sel_d = key_sel_q;
    if (io_out && (io_n == IO_N_KEYSEL)) key_sel_d = io_dout[3:0];

    ef3_d = ~key_bit(keys_q[0], key_sel_q);
    ef4_d = ~key_bit(keys_q[1], key_sel_q);
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      toggle_q  <= 1'b0;
      key_sel_q <= KEY_NONE;
      ef3_q     <= 1'b1;
      ef4_q     <= 1'b1;
      for (int p = 0; p < NUM_PADS; p++) begin
        keys_q[p] <= '0;
        pend_q[p] <= '0;
        cnt_q[p]  <= '0;
      end
    end else begin
      toggle_q  <= ps2_key[10];
      key_sel_q <= key_sel_d;
      ef3_q     <= ef3_d;
      ef4_q     <= ef4_d;
      for (int p = 0; p < NUM_PADS; p++) begin
        keys_q[p] <= keys_d[p];
        pend_q[p] <= pend_d[p];
        cnt_q[p]  <= cnt_d[p];
      end
    end
  end

  assign kp1_keys = keys_q[0];
  assign kp2_keys = keys_q[1];
  assign key_sel  = key_sel_q;
  assign ef3_n    = ef3_q;
  assign ef4_n    = ef4_q;

endmodule
